// File: rtl/pipe_cla_pkg.sv
// Shared constants and block-carry lookahead for the pipelined 32-bit CLA.
package pipe_cla_pkg;

    localparam int DATA_W       = 32;
    localparam int BLK_W        = 4;
    localparam int HALF_W       = 16;
    localparam int NUM_BLK      = DATA_W / BLK_W;
    localparam int BLK_PER_HALF = NUM_BLK / 2;

    // Four-way carry lookahead. Bit 0 of the result is the carry-in and bit 4
    // is the carry out of the group. Every term is flattened so that no carry
    // ripples through a previous carry.
    function automatic logic [4:0] lookahead4(input logic [3:0] g,
                                              input logic [3:0] p,
                                              input logic       ci);
        logic [4:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead block: local sum plus block generate/propagate,
// which the top-level lookahead uses to form the inter-block carries.
module cla_4bit
    import pipe_cla_pkg::*;
(
    input  logic [BLK_W-1:0] a,
    input  logic [BLK_W-1:0] b,
    input  logic             ci,
    output logic [BLK_W-1:0] s,
    output logic             G,
    output logic             P
);

    logic [BLK_W-1:0] g;
    logic [BLK_W-1:0] p;
    logic [BLK_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;
    assign c = lookahead4(g, p, ci);
    assign s = p ^ c[BLK_W-1:0];

    // Block generate/propagate do not depend on ci, so the upper lookahead
    // level sees no path back through this block's carry-in.
    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    assign P = &p;

endmodule

// File: rtl/pipe_cla_32bit.sv
// Two-stage pipelined 32-bit carry-lookahead adder: {cout, sum} = A + B + cin.
// The low half resolves in stage 1, the high half in stage 2, and the carry
// between the halves is registered between them. RESETn is active-high even
// though its name suggests otherwise.
// Build option: define PIPE_CLA_IN_REG_EN to add an input register stage,
// which raises the latency from 2 to 3 edges.
module pipe_cla_32bit
    import pipe_cla_pkg::*;
(
    input  logic              CLK,
    input  logic              RESETn,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              cin_in;

`ifdef PIPE_CLA_IN_REG_EN
    // Input capture stage ahead of the adder.
    always_ff @(posedge CLK or posedge RESETn) begin
        if (RESETn) begin
            a_in   <= '0;
            b_in   <= '0;
            cin_in <= 1'b0;
        end else begin
            a_in   <= A;
            b_in   <= B;
            cin_in <= cin;
        end
    end
`else
    assign a_in   = A;
    assign b_in   = B;
    assign cin_in = cin;
`endif

    // Stage 1: low half, combinational from the operands.
    logic [BLK_PER_HALF-1:0] g_lo;
    logic [BLK_PER_HALF-1:0] p_lo;
    logic [BLK_PER_HALF:0]   c_lo;
    logic [HALF_W-1:0]       s_lo;

    assign c_lo = lookahead4(g_lo, p_lo, cin_in);

    for (genvar i = 0; i < BLK_PER_HALF; i++) begin : gen_lo_blk
        cla_4bit u_cla (
            .a  (a_in[i*BLK_W +: BLK_W]),
            .b  (b_in[i*BLK_W +: BLK_W]),
            .ci (c_lo[i]),
            .s  (s_lo[i*BLK_W +: BLK_W]),
            .G  (g_lo[i]),
            .P  (p_lo[i])
        );
    end

    logic [HALF_W-1:0] s1_sum_lo;
    logic              s1_c16;
    logic [HALF_W-1:0] s1_a_hi;
    logic [HALF_W-1:0] s1_b_hi;

    // Stage-1 registers: resolved low half, mid carry, and the untouched high operands.
    always_ff @(posedge CLK or posedge RESETn) begin
        if (RESETn) begin
            s1_sum_lo <= '0;
            s1_c16    <= 1'b0;
            s1_a_hi   <= '0;
            s1_b_hi   <= '0;
        end else begin
            s1_sum_lo <= s_lo;
            s1_c16    <= c_lo[BLK_PER_HALF];
            s1_a_hi   <= a_in[DATA_W-1:HALF_W];
            s1_b_hi   <= b_in[DATA_W-1:HALF_W];
        end
    end

    // Stage 2: high half, combinational from the stage-1 registers.
    logic [BLK_PER_HALF-1:0] g_hi;
    logic [BLK_PER_HALF-1:0] p_hi;
    logic [BLK_PER_HALF:0]   c_hi;
    logic [HALF_W-1:0]       s_hi;

    assign c_hi = lookahead4(g_hi, p_hi, s1_c16);

    for (genvar i = 0; i < BLK_PER_HALF; i++) begin : gen_hi_blk
        cla_4bit u_cla (
            .a  (s1_a_hi[i*BLK_W +: BLK_W]),
            .b  (s1_b_hi[i*BLK_W +: BLK_W]),
            .ci (c_hi[i]),
            .s  (s_hi[i*BLK_W +: BLK_W]),
            .G  (g_hi[i]),
            .P  (p_hi[i])
        );
    end

    // Output registers: the low half is forwarded so both halves land together.
    always_ff @(posedge CLK or posedge RESETn) begin
        if (RESETn) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= {s_hi, s1_sum_lo};
            cout <= c_hi[BLK_PER_HALF];
        end
    end

endmodule

// File: tb/tb_pipe_cla_32bit.sv
// Directed and random checks for pipe_cla_32bit against a 33-bit A+B+cin model.
module tb_pipe_cla_32bit;

`ifdef PIPE_CLA_IN_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        CLK = 1'b0;
    logic        RESETn = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        cin = 1'b0;
    logic [31:0] sum;
    logic        cout;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_cla_32bit dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .A      (A),
        .B      (B),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got %0t required < 2000000", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic c);
        return {1'b0, a} + {1'b0, b} + {32'd0, c};
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c);
        A = a;
        B = b;
        cin = c;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        drive(32'h1234_5678, 32'h0000_0001, 1'b1);
        RESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({cout, sum} !== 33'h0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got cout=%0b sum=%h required cout=0 sum=00000000",
                         i, cout, sum);
            end
        end
        // First result after release must come exactly LAT edges after the first sample.
        RESETn = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            tick();
            n_cmp++;
            if ({cout, sum} !== 33'h0) begin
                n_fail++;
                $display("FAIL reset_release_zero[%0d]: got cout=%0b sum=%h required 0",
                         i, cout, sum);
            end
        end
        tick();
        n_cmp++;
        if ({cout, sum} !== {1'b0, 32'h1234_567A}) begin
            n_fail++;
            $display("FAIL reset_first_result: got cout=%0b sum=%h required cout=0 sum=1234567a",
                     cout, sum);
        end
    endtask

    task automatic test_half_carry();
        drive(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        for (int i = 0; i < LAT; i++) tick();
        n_cmp++;
        if ({cout, sum} !== {1'b0, 32'h0001_0000}) begin
            n_fail++;
            $display("FAIL half_carry: got cout=%0b sum=%h required cout=0 sum=00010000",
                     cout, sum);
        end
        drive(32'h0000_7FFF, 32'h0000_8000, 1'b1);
        for (int i = 0; i < LAT; i++) tick();
        n_cmp++;
        if ({cout, sum} !== {1'b0, 32'h0001_0000}) begin
            n_fail++;
            $display("FAIL half_carry_cin: got cout=%0b sum=%h required cout=0 sum=00010000",
                     cout, sum);
        end
    endtask

    // Back-to-back full-carry vectors; results must come out on consecutive edges.
    task automatic test_full_carry();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic        vc [3];
        logic [32:0] ve [3];
        va = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        vb = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        vc = '{1'b1, 1'b0, 1'b1};
        ve = '{{1'b1, 32'h0000_0000}, {1'b1, 32'h0000_0000}, {1'b1, 32'hFFFF_FFFF}};
        for (int t = 0; t < 3 + LAT - 1; t++) begin
            if (t < 3) drive(va[t], vb[t], vc[t]);
            tick();
            if (t >= LAT - 1) begin
                n_cmp++;
                if ({cout, sum} !== ve[t-LAT+1]) begin
                    n_fail++;
                    $display("FAIL full_carry[%0d]: got cout=%0b sum=%h required cout=%0b sum=%h",
                             t - LAT + 1, cout, sum, ve[t-LAT+1][32], ve[t-LAT+1][31:0]);
                end
            end
        end
    endtask

    task automatic test_streaming();
        logic [32:0] exp_q [$];
        logic [32:0] e;
        for (int t = 0; t < 16 + LAT - 1; t++) begin
            if (t < 16) begin
                drive(32'(30000 * t), 32'(50000 * t), 1'b0);
                exp_q.push_back({1'b0, 32'(80000 * t)});
            end
            tick();
            if (t >= LAT - 1) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({cout, sum} !== e) begin
                    n_fail++;
                    $display("FAIL streaming[%0d]: got cout=%0b sum=%0d required cout=%0b sum=%0d",
                             t - LAT + 1, cout, sum, e[32], e[31:0]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [32:0] exp_q [$];
        logic [32:0] e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        int          nerr;
        nerr = 0;
        for (int t = 0; t < 10000 + LAT - 1; t++) begin
            if (t < 10000) begin
                ra = $urandom;
                rb = $urandom;
                rc = 1'($urandom_range(1, 0));
                drive(ra, rb, rc);
                exp_q.push_back(model(ra, rb, rc));
            end
            tick();
            if (t >= LAT - 1) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({cout, sum} !== e) begin
                    n_fail++;
                    nerr++;
                    if (nerr <= 10)
                        $display("FAIL random[%0d]: got cout=%0b sum=%h required cout=%0b sum=%h",
                                 t - LAT + 1, cout, sum, e[32], e[31:0]);
                end
            end
        end
    endtask

    // Reset asserted between edges must clear the outputs without a clock edge.
    task automatic test_async_reset();
        drive(32'hFFFF_0000, 32'h0001_FFFF, 1'b1);
        for (int i = 0; i < LAT; i++) tick();
        n_cmp++;
        if ({cout, sum} !== {1'b1, 32'h0001_0000}) begin
            n_fail++;
            $display("FAIL async_pre: got cout=%0b sum=%h required cout=1 sum=00010000",
                     cout, sum);
        end
        #2;
        RESETn = 1'b1;
        #1;
        n_cmp++;
        if ({cout, sum} !== 33'h0) begin
            n_fail++;
            $display("FAIL async_reset: got cout=%0b sum=%h required cout=0 sum=00000000",
                     cout, sum);
        end
        tick();
        n_cmp++;
        if ({cout, sum} !== 33'h0) begin
            n_fail++;
            $display("FAIL async_reset_hold: got cout=%0b sum=%h required 0", cout, sum);
        end
        // In-flight operands were discarded, so the first output after release is 0.
        RESETn = 1'b0;
        drive(32'h0000_0005, 32'h0000_0006, 1'b0);
        tick();
        n_cmp++;
        if ({cout, sum} !== 33'h0) begin
            n_fail++;
            $display("FAIL async_discard: got cout=%0b sum=%h required 0", cout, sum);
        end
        for (int i = 0; i < LAT - 1; i++) tick();
        n_cmp++;
        if ({cout, sum} !== {1'b0, 32'h0000_000B}) begin
            n_fail++;
            $display("FAIL async_recover: got cout=%0b sum=%h required cout=0 sum=0000000b",
                     cout, sum);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_half_carry();
        test_full_carry();
        test_streaming();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
